cpi_global_conn_ctrl: RTL and testbench
=======================================

Name: cpi_global_conn_ctrl

Overview:
- Agent-side controller for the CPI global connect/disconnect handshake, generalised to NUM_CH independent channels.
- Each channel runs its own txcon_req/rxcon_ack/rxdiscon_nack state machine with a timeout watchdog.
- Aggregates per-channel errors into sticky fatal/viral outputs and maintains a connect epoch counter.
- Sits between agent control logic (software-level connect requests) and the fabric-facing CPI global signals.

Parameters:
- NUM_CH, 2, number of independent CPI global channels (1..16).
- EPOCH_W, 10, width of epoch_id.
- TIMEOUT_CYC, 1024, cycles a channel may wait in CONN_REQ or DISC_REQ before timeout (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- conn_req_i  in  NUM_CH  per-channel level request: 1 = want connected, 0 = want disconnected.
- clr_err_i  in  1  single-cycle pulse; clears fatal and timeout_o.
- viral_i  in  1  external viral indication.
- txcon_req  out  NUM_CH  connect request to fabric.
- rxcon_ack  in  NUM_CH  connect acknowledge from fabric.
- rxdiscon_nack  in  NUM_CH  disconnect refusal from fabric.
- rx_empty  in  NUM_CH  fabric receive queue empty.
- conn_state_o  out  2*NUM_CH  per-channel state, channel i at bits [2i+1:2i].
- timeout_o  out  NUM_CH  sticky per-channel timeout flag.
- fatal  out  1  sticky fatal error.
- viral  out  1  sticky viral indication.
- epoch_id  out  EPOCH_W  connect epoch counter.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: all channels in DISC; txcon_req=0, conn_state_o=0, timeout_o=0, fatal=0, viral=0, epoch_id=0.
- All outputs are registered. txcon_req[i]=1 exactly when channel i is in CONN_REQ or CONN.
- Per-channel states (encoding): DISC=0, CONN_REQ=1, CONN=2, DISC_REQ=3.
- DISC -> CONN_REQ: when conn_req_i=1 and rxcon_ack=0. If rxcon_ack is still 1, stay in DISC.
- CONN_REQ -> CONN: on rxcon_ack=1.
- CONN_REQ timeout: if still in CONN_REQ after TIMEOUT_CYC cycles, go to DISC, set timeout_o[i], raise a fatal event.
- CONN_REQ abort: conn_req_i dropping in CONN_REQ does not abort; the handshake completes first.
- CONN -> DISC_REQ: when conn_req_i=0 and rx_empty=1. If rx_empty=0, hold in CONN.
- CONN unexpected ack loss: rxcon_ack=0 while in CONN -> go to DISC, raise a fatal event.
- DISC_REQ -> CONN: on rxdiscon_nack=1; txcon_req reasserts next cycle. Nack has priority over a same-cycle rxcon_ack=0.
- DISC_REQ -> DISC: on rxcon_ack=0 with nack=0.
- DISC_REQ timeout: same rule as CONN_REQ (after TIMEOUT_CYC cycles -> DISC, set timeout_o[i], fatal event).
- Timer: one per channel, width $clog2(TIMEOUT_CYC+1). Cleared on entering any state; increments only in CONN_REQ and DISC_REQ. Timeout fires on the cycle the count reaches TIMEOUT_CYC-1 without the exit condition; a valid exit on that same cycle wins over the timeout.
- fatal: set by any channel fatal event. clr_err_i clears fatal and all timeout_o bits; a same-cycle new event wins (flag stays/sets).
- viral: set by viral_i or any fatal event. Never cleared by clr_err_i; cleared only by reset.
- epoch_id: +1 in any cycle where at least one channel enters CONN, including re-entry from DISC_REQ via nack. Multiple simultaneous entries still count +1. Wraps from 2^EPOCH_W-1 to 0.
- Reset mid-handshake: asynchronous return to reset values; txcon_req drops immediately.

Test Plan (NUM_CH=2, EPOCH_W=10, TIMEOUT_CYC=16):
- Connect ch0: conn_req_i=01, fabric acks 3 cycles after txcon_req -> txcon_req[0]=1 one cycle after request; state 1 then 2; epoch_id 0->1; fatal=0.
- Disconnect with nack: from CONN, drop conn_req_i[0] with rx_empty=1, fabric asserts rxdiscon_nack -> state 3 then 2, txcon_req[0] back to 1, epoch_id increments; repeat without nack, ack drops -> state 0.
- rx_empty hold: conn_req_i[1]=0 while rx_empty[1]=0 for 10 cycles -> stays CONN, txcon_req[1]=1; rx_empty rises -> DISC_REQ next cycle.
- Timeout: request ch1, never ack -> after 16 cycles state 0, timeout_o=10, fatal=1, viral=1. Pulse clr_err_i -> fatal=0, timeout_o=0, viral stays 1.
- Simultaneous: both channels acked same cycle -> epoch_id +1 only. epoch_id at 1023 plus a connect -> 0.
- Unexpected ack loss in CONN plus clr_err_i in the same cycle -> fatal=1; rst_n low mid CONN_REQ -> txcon_req=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/cpi_global_conn_ctrl.sv
// CPI global connect/disconnect handshake controller, one FSM per channel.
// Channel errors fold into sticky fatal/viral flags; connects bump the epoch.
module cpi_global_conn_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int EPOCH_W     = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     conn_req_i,
  input  logic                  clr_err_i,
  input  logic                  viral_i,
  output logic [NUM_CH-1:0]     txcon_req,
  input  logic [NUM_CH-1:0]     rxcon_ack,
  input  logic [NUM_CH-1:0]     rxdiscon_nack,
  input  logic [NUM_CH-1:0]     rx_empty,
  output logic [2*NUM_CH-1:0]   conn_state_o,
  output logic [NUM_CH-1:0]     timeout_o,
  output logic                  fatal,
  output logic                  viral,
  output logic [EPOCH_W-1:0]    epoch_id
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_DISC     = 2'd0;
  localparam logic [1:0] S_CONN_REQ = 2'd1;
  localparam logic [1:0] S_CONN     = 2'd2;
  localparam logic [1:0] S_DISC_REQ = 2'd3;

  logic [1:0]         st_q  [NUM_CH];
  logic [1:0]         st_d  [NUM_CH];
  logic [TW-1:0]      tmr_q [NUM_CH];
  logic [TW-1:0]      tmr_d [NUM_CH];

  logic [NUM_CH-1:0]  to_ev;
  logic [NUM_CH-1:0]  ft_ev;
  logic [NUM_CH-1:0]  en_conn;

  logic [NUM_CH-1:0]  txcon_q, txcon_d;
  logic [NUM_CH-1:0]  timeout_q, timeout_d;
  logic               fatal_q, fatal_d;
  logic               viral_q, viral_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= S_DISC;
        tmr_q[i] <= '0;
      end
      txcon_q   <= '0;
      timeout_q <= '0;
      fatal_q   <= 1'b0;
      viral_q   <= 1'b0;
      epoch_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      txcon_q   <= txcon_d;
      timeout_q <= timeout_d;
      fatal_q   <= fatal_d;
      viral_q   <= viral_d;
      epoch_q   <= epoch_d;
    end
  end

  // Per-channel next state, watchdog timer and event strobes
  always_comb begin
    to_ev   = '0;
    ft_ev   = '0;
    en_conn = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      unique case (st_q[i])
        S_DISC: begin
          if (conn_req_i[i] && !rxcon_ack[i])
            st_d[i] = S_CONN_REQ;
        end
        S_CONN_REQ: begin
          if (rxcon_ack[i]) begin
            st_d[i]    = S_CONN;
            en_conn[i] = 1'b1;
          end else if (tmr_q[i] == T_LAST) begin
            st_d[i]  = S_DISC;
            to_ev[i] = 1'b1;
            ft_ev[i] = 1'b1;
          end
        end
        S_CONN: begin
          if (!rxcon_ack[i]) begin
            st_d[i]  = S_DISC;
            ft_ev[i] = 1'b1;
          end else if (!conn_req_i[i] && rx_empty[i]) begin
            st_d[i] = S_DISC_REQ;
          end
        end
        S_DISC_REQ: begin
          if (rxdiscon_nack[i]) begin
            st_d[i]    = S_CONN;
            en_conn[i] = 1'b1;
          end else if (!rxcon_ack[i]) begin
            st_d[i] = S_DISC;
          end else if (tmr_q[i] == T_LAST) begin
            st_d[i]  = S_DISC;
            to_ev[i] = 1'b1;
            ft_ev[i] = 1'b1;
          end
        end
        default: st_d[i] = S_DISC;
      endcase
      // Timer restarts on any state entry and only runs while waiting
      if (st_d[i] != st_q[i])
        tmr_d[i] = '0;
      else if (st_q[i] == S_CONN_REQ || st_q[i] == S_DISC_REQ)
        tmr_d[i] = tmr_q[i] + TW'(1);
    end
  end

  // Next values of the registered outputs; new events beat clr_err_i
  always_comb begin
    txcon_d   = '0;
    for (int i = 0; i < NUM_CH; i++)
      txcon_d[i] = (st_d[i] == S_CONN_REQ) || (st_d[i] == S_CONN);
    timeout_d = to_ev | (timeout_q & {NUM_CH{~clr_err_i}});
    fatal_d   = (|ft_ev) | (fatal_q & ~clr_err_i);
    viral_d   = viral_q | viral_i | (|ft_ev);
    epoch_d   = (|en_conn) ? epoch_q + EPOCH_W'(1) : epoch_q;
  end

  // Flatten per-channel state onto the output bus
  always_comb begin
    conn_state_o = '0;
    for (int i = 0; i < NUM_CH; i++)
      conn_state_o[2*i +: 2] = st_q[i];
  end

  assign txcon_req = txcon_q;
  assign timeout_o = timeout_q;
  assign fatal     = fatal_q;
  assign viral     = viral_q;
  assign epoch_id  = epoch_q;

endmodule

// File: tb/tb_cpi_global_conn_ctrl.sv
// Directed bench for cpi_global_conn_ctrl (2 channels, 16-cycle timeout).
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_cpi_global_conn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] conn_req_i = '0;
  logic       clr_err_i = 1'b0;
  logic       viral_i = 1'b0;
  logic [1:0] txcon_req;
  logic [1:0] rxcon_ack = '0;
  logic [1:0] rxdiscon_nack = '0;
  logic [1:0] rx_empty = '0;
  logic [3:0] conn_state_o;
  logic [1:0] timeout_o;
  logic       fatal;
  logic       viral;
  logic [9:0] epoch_id;

  int total = 0;
  int bad = 0;

  cpi_global_conn_ctrl #(
    .NUM_CH(2), .EPOCH_W(10), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .conn_req_i(conn_req_i), .clr_err_i(clr_err_i),
    .viral_i(viral_i), .txcon_req(txcon_req),
    .rxcon_ack(rxcon_ack), .rxdiscon_nack(rxdiscon_nack),
    .rx_empty(rx_empty), .conn_state_o(conn_state_o),
    .timeout_o(timeout_o), .fatal(fatal), .viral(viral),
    .epoch_id(epoch_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    conn_req_i = '0; clr_err_i = 0; viral_i = 0;
    rxcon_ack = '0; rxdiscon_nack = '0; rx_empty = '0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({txcon_req, conn_state_o, timeout_o, fatal, viral, epoch_id} !== '0) begin
      bad++;
      $display("FAIL reset: got tx=%b st=%b to=%b f=%b v=%b ep=%0d want all 0",
               txcon_req, conn_state_o, timeout_o, fatal, viral, epoch_id);
    end
  endtask

  task automatic test_connect();
    conn_req_i = 2'b01;
    step();
    total++;
    if (txcon_req !== 2'b01 || conn_state_o !== 4'b0001) begin
      bad++;
      $display("FAIL conn_req: tx=%b st=%b want 01/0001", txcon_req, conn_state_o);
    end
    step();
    step();
    rxcon_ack = 2'b01;
    step();
    total++;
    if (conn_state_o !== 4'b0010 || epoch_id !== 10'd1 || fatal !== 1'b0) begin
      bad++;
      $display("FAIL conn: st=%b ep=%0d f=%b want 0010/1/0", conn_state_o, epoch_id, fatal);
    end
  endtask

  task automatic test_disc_nack();
    conn_req_i = 2'b00;
    rx_empty = 2'b01;
    step();
    total++;
    if (conn_state_o !== 4'b0011 || txcon_req !== 2'b00) begin
      bad++;
      $display("FAIL disc_req: st=%b tx=%b want 0011/00", conn_state_o, txcon_req);
    end
    rxdiscon_nack = 2'b01;
    step();
    rxdiscon_nack = 2'b00;
    total++;
    if (conn_state_o !== 4'b0010 || txcon_req !== 2'b01 || epoch_id !== 10'd2) begin
      bad++;
      $display("FAIL nack: st=%b tx=%b ep=%0d want 0010/01/2",
               conn_state_o, txcon_req, epoch_id);
    end
    step();
    total++;
    if (conn_state_o !== 4'b0011) begin
      bad++;
      $display("FAIL disc_req2: st=%b want 0011", conn_state_o);
    end
    rxcon_ack = 2'b00;
    step();
    total++;
    if (conn_state_o !== 4'b0000 || fatal !== 1'b0 || epoch_id !== 10'd2) begin
      bad++;
      $display("FAIL disc: st=%b f=%b ep=%0d want 0000/0/2", conn_state_o, fatal, epoch_id);
    end
    rx_empty = 2'b00;
  endtask

  task automatic test_rx_empty_hold();
    int held = 0;
    conn_req_i = 2'b10;
    step();
    rxcon_ack = 2'b10;
    step();
    conn_req_i = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      if (conn_state_o === 4'b1000 && txcon_req === 2'b10) held++;
    end
    total++;
    if (held !== 10 || epoch_id !== 10'd3) begin
      bad++;
      $display("FAIL hold: held=%0d ep=%0d want 10/3", held, epoch_id);
    end
    rx_empty = 2'b10;
    step();
    total++;
    if (conn_state_o !== 4'b1100) begin
      bad++;
      $display("FAIL hold_rel: st=%b want 1100", conn_state_o);
    end
    rxcon_ack = 2'b00;
    rx_empty = 2'b00;
    step();
  endtask

  task automatic test_timeout();
    conn_req_i = 2'b10;
    step();
    conn_req_i = 2'b00;
    for (int i = 0; i < 15; i++) step();
    total++;
    if (conn_state_o !== 4'b0100 || fatal !== 1'b0) begin
      bad++;
      $display("FAIL to_pre: st=%b f=%b want 0100/0", conn_state_o, fatal);
    end
    step();
    total++;
    if (conn_state_o !== 4'b0000 || timeout_o !== 2'b10 || fatal !== 1'b1 || viral !== 1'b1) begin
      bad++;
      $display("FAIL to: st=%b to=%b f=%b v=%b want 0000/10/1/1",
               conn_state_o, timeout_o, fatal, viral);
    end
    clr_err_i = 1;
    step();
    clr_err_i = 0;
    total++;
    if (fatal !== 1'b0 || timeout_o !== 2'b00 || viral !== 1'b1) begin
      bad++;
      $display("FAIL clr: f=%b to=%b v=%b want 0/00/1", fatal, timeout_o, viral);
    end
  endtask

  task automatic test_simul_wrap();
    conn_req_i = 2'b11;
    step();
    rxcon_ack = 2'b11;
    step();
    total++;
    if (conn_state_o !== 4'b1010 || epoch_id !== 10'd4) begin
      bad++;
      $display("FAIL simul: st=%b ep=%0d want 1010/4", conn_state_o, epoch_id);
    end
    conn_req_i = 2'b10;
    rx_empty = 2'b01;
    for (int i = 0; i < 1019; i++) begin
      step();
      rxdiscon_nack = 2'b01;
      step();
      rxdiscon_nack = 2'b00;
    end
    total++;
    if (epoch_id !== 10'd1023) begin
      bad++;
      $display("FAIL ep_max: ep=%0d want 1023", epoch_id);
    end
    step();
    rxdiscon_nack = 2'b01;
    step();
    rxdiscon_nack = 2'b00;
    total++;
    if (epoch_id !== 10'd0 || conn_state_o !== 4'b1010) begin
      bad++;
      $display("FAIL ep_wrap: ep=%0d st=%b want 0/1010", epoch_id, conn_state_o);
    end
  endtask

  task automatic test_nack_priority();
    step();
    rxdiscon_nack = 2'b01;
    rxcon_ack = 2'b10;
    step();
    rxdiscon_nack = 2'b00;
    rxcon_ack = 2'b11;
    total++;
    if (conn_state_o !== 4'b1010 || epoch_id !== 10'd1) begin
      bad++;
      $display("FAIL nack_pri: st=%b ep=%0d want 1010/1", conn_state_o, epoch_id);
    end
    step();
    total++;
    if (conn_state_o !== 4'b1011 || fatal !== 1'b0) begin
      bad++;
      $display("FAIL nack_pri2: st=%b f=%b want 1011/0", conn_state_o, fatal);
    end
  endtask

  task automatic test_ack_loss_clr();
    rxcon_ack = 2'b01;
    clr_err_i = 1;
    step();
    clr_err_i = 0;
    total++;
    if (fatal !== 1'b1 || conn_state_o !== 4'b0011 || viral !== 1'b1) begin
      bad++;
      $display("FAIL ack_loss: f=%b st=%b v=%b want 1/0011/1", fatal, conn_state_o, viral);
    end
  endtask

  task automatic test_reset_mid();
    rx_empty = 2'b00;
    rxcon_ack = 2'b01;
    conn_req_i = 2'b11;
    step();
    total++;
    if (txcon_req !== 2'b10 || conn_state_o !== 4'b0111) begin
      bad++;
      $display("FAIL pre_rst: tx=%b st=%b want 10/0111", txcon_req, conn_state_o);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({txcon_req, conn_state_o, timeout_o, fatal, viral, epoch_id} !== '0) begin
      bad++;
      $display("FAIL rst_mid: tx=%b st=%b to=%b f=%b v=%b ep=%0d want all 0",
               txcon_req, conn_state_o, timeout_o, fatal, viral, epoch_id);
    end
    do_reset();
  endtask

  task automatic test_timeout_edge();
    rxcon_ack = 2'b01;
    conn_req_i = 2'b01;
    step();
    total++;
    if (conn_state_o !== 4'b0000) begin
      bad++;
      $display("FAIL stale_ack: st=%b want 0000", conn_state_o);
    end
    rxcon_ack = 2'b00;
    step();
    for (int i = 0; i < 15; i++) step();
    rxcon_ack = 2'b01;
    step();
    total++;
    if (conn_state_o !== 4'b0010 || timeout_o !== 2'b00 || fatal !== 1'b0 || epoch_id !== 10'd1) begin
      bad++;
      $display("FAIL to_edge: st=%b to=%b f=%b ep=%0d want 0010/00/0/1",
               conn_state_o, timeout_o, fatal, epoch_id);
    end
  endtask

  task automatic test_viral_in();
    viral_i = 1;
    step();
    viral_i = 0;
    clr_err_i = 1;
    step();
    clr_err_i = 0;
    total++;
    if (viral !== 1'b1 || fatal !== 1'b0) begin
      bad++;
      $display("FAIL viral_in: v=%b f=%b want 1/0", viral, fatal);
    end
  endtask

  initial begin
    test_reset();
    test_connect();
    test_disc_nack();
    test_rx_empty_hold();
    test_timeout();
    test_simul_wrap();
    test_nack_priority();
    test_ack_loss_clr();
    test_reset_mid();
    test_timeout_edge();
    test_viral_in();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
